// File: rtl/op_recover_pkg.sv
// Shared constants, entry layout and the inverse-arithmetic helper for op_recover.
package op_recover_pkg;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned ENTRY_W    = 9;
    localparam int unsigned DATA_W     = 8;

    localparam bit OP_SUB = 1'b0;
    localparam bit OP_SUM = 1'b1;

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] b;
    } entry_t;

    // 9-bit modulo difference; bit 8 flags a b that cannot fit in 8 bits.
    function automatic entry_t recover(input bit op, input logic [DATA_W-1:0] a,
                                       input logic [DATA_W:0] res);
        logic [DATA_W:0] d;
        d = (op == OP_SUM) ? (res - {1'b0, a}) : ({1'b0, a} - res);
        return '{err: d[DATA_W], b: d[DATA_W-1:0]};
    endfunction

endpackage

// File: rtl/recover_fifo.sv
// Small first-in first-out buffer with a combinational head; a pop frees room for a
// push on the same edge, so a full FIFO can accept a write when it is also read.
module recover_fifo #(
    parameter int unsigned width = 9,
    parameter int unsigned depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] wdata,
    input  logic             pop,
    output logic [width-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = $clog2(depth);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      cnt;
    logic [width-1:0] mem [depth];
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (cnt == '0);
        full    = (cnt == (PW+1)'(depth));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata   = mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: only entries below the occupancy count are ever shown.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/op_recover.sv
// Recovers operand b of an upstream add/sub stage from its operand a and result, and
// queues {err, b} for a ready/valid consumer.
module op_recover
    import op_recover_pkg::*;
#(
    parameter bit          OP  = OP_SUM,
    parameter int unsigned LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W:0]   res,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] b_out,
    output logic              b_err,
    output logic              ovf,
    output logic [7:0]        err_cnt
);

    logic [LAT-1:0]    dly_v;
    logic [DATA_W-1:0] dly_a [LAT];
    logic              wr;
    logic              drop;
    logic              fifo_full;
    logic              fifo_empty;
    entry_t            ent;
    entry_t            head;

    // Valid bits reset so nothing in flight survives a reset; operand data need not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_v <= '0;
        end else begin
            dly_v[0] <= a_valid;
            for (int unsigned i = 1; i < LAT; i++) begin
                dly_v[i] <= dly_v[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        dly_a[0] <= a;
        for (int unsigned i = 1; i < LAT; i++) begin
            dly_a[i] <= dly_a[i-1];
        end
    end

    always_comb begin
        wr   = dly_v[LAT-1];
        ent  = recover(OP, dly_a[LAT-1], res);
        // A full FIFO is never empty, so out_ready alone decides whether a pop frees room.
        drop = wr && fifo_full && !out_ready;
    end

    recover_fifo #(
        .width (ENTRY_W),
        .depth (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr),
        .wdata (ent),
        .pop   (out_ready),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        out_valid = !fifo_empty;
        b_out     = head.b;
        b_err     = head.err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf     <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (drop) begin
                ovf <= 1'b1;
            end
            if (wr && !drop && ent.err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_op_recover.sv
// Randomised and directed bench for op_recover: a sum instance and a sub instance run side
// by side against a queue-based reference model.
module tb_op_recover;

    localparam int unsigned LAT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid;
    logic [7:0] a;
    logic [8:0] res1, res0;
    logic       out_ready;

    logic       out_valid1, b_err1, ovf1;
    logic [7:0] b_out1, err_cnt1;
    logic       out_valid0, b_err0, ovf0;
    logic [7:0] b_out0, err_cnt0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: issued operands awaiting their result, and the expected FIFO contents.
    logic [8:0] hist[$];
    logic [8:0] q1[$];
    logic [8:0] q0[$];
    logic       ovf_m1, ovf_m0;
    int         ec_m1, ec_m0;

    op_recover #(.OP(1'b1), .LAT(LAT)) u_sum (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a         (a),
        .res       (res1),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .b_out     (b_out1),
        .b_err     (b_err1),
        .ovf       (ovf1),
        .err_cnt   (err_cnt1)
    );

    op_recover #(.OP(1'b0), .LAT(LAT)) u_sub (
        .clk       (clk),
        .rst       (rst),
        .a_valid   (a_valid),
        .a         (a),
        .res       (res0),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .b_out     (b_out0),
        .b_err     (b_err0),
        .ovf       (ovf0),
        .err_cnt   (err_cnt0)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] rec(input bit op, input int av, input int rv);
        int d;
        d = op ? (rv - av) : (av - rv);
        if (d < 0) d += 512;
        return {(d >= 256) ? 1'b1 : 1'b0, 8'(d % 256)};
    endfunction

    task automatic compare_outputs();
        check("sum.valid", 32'(out_valid1), 32'(q1.size() > 0));
        if (q1.size() > 0) check("sum.head", 32'({b_err1, b_out1}), 32'(q1[0]));
        check("sum.ovf", 32'(ovf1), 32'(ovf_m1));
        check("sum.err_cnt", 32'(err_cnt1), 32'(ec_m1));
        check("sub.valid", 32'(out_valid0), 32'(q0.size() > 0));
        if (q0.size() > 0) check("sub.head", 32'({b_err0, b_out0}), 32'(q0[0]));
        check("sub.ovf", 32'(ovf0), 32'(ovf_m0));
        check("sub.err_cnt", 32'(err_cnt0), 32'(ec_m0));
    endtask

    // Called at a falling edge; applies inputs, predicts the next rising edge, then checks.
    task automatic cycle(input logic av, input logic [7:0] av_a, input logic [8:0] r1,
                         input logic [8:0] r0, input logic rdy);
        logic [8:0] e;
        logic [8:0] ent;
        a_valid   = av;
        a         = av_a;
        res1      = r1;
        res0      = r0;
        out_ready = rdy;

        e = hist.pop_front();
        hist.push_back({av, av_a});

        if (rdy && q1.size() > 0) void'(q1.pop_front());
        if (rdy && q0.size() > 0) void'(q0.pop_front());
        if (e[8]) begin
            ent = rec(1'b1, int'(e[7:0]), int'(r1));
            if (q1.size() < 4) begin
                q1.push_back(ent);
                if (ent[8] && ec_m1 < 255) ec_m1++;
            end else begin
                ovf_m1 = 1'b1;
            end
            ent = rec(1'b0, int'(e[7:0]), int'(r0));
            if (q0.size() < 4) begin
                q0.push_back(ent);
                if (ent[8] && ec_m0 < 255) ec_m0++;
            end else begin
                ovf_m0 = 1'b1;
            end
        end

        @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        a_valid   = 1'b0;
        out_ready = 1'b0;
        hist.delete();
        repeat (LAT) hist.push_back(9'd0);
        q1.delete();
        q0.delete();
        ovf_m1 = 1'b0;
        ovf_m0 = 1'b0;
        ec_m1  = 0;
        ec_m0  = 0;
        #1;
        compare_outputs();
        @(posedge clk);
        #1;
        compare_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        a_valid   = 1'b0;
        a         = '0;
        res1      = '0;
        res0      = '0;
        out_ready = 1'b0;
        @(negedge clk);
        reset_dut();

        // Directed recoveries: with the consumer always ready the head is the newest write.
        cycle(1'b1, 8'd200, 9'd0, 9'd0, 1'b1);
        cycle(1'b1, 8'd50, 9'd0, 9'd0, 1'b1);
        cycle(1'b1, 8'd10, 9'd0, 9'd0, 1'b1);
        cycle(1'b0, 8'd0, 9'd300, 9'd0, 1'b1);
        check("dir.sum_b", 32'({b_err1, b_out1}), 32'd100);
        check("dir.sum_cnt0", 32'(err_cnt1), 32'd0);
        cycle(1'b0, 8'd0, 9'd20, 9'd0, 1'b1);
        check("dir.sum_err_b", 32'({b_err1, b_out1}), 32'(9'h100 + 9'd226));
        check("dir.sum_cnt1", 32'(err_cnt1), 32'd1);
        cycle(1'b0, 8'd0, 9'd20, 9'h1FB, 1'b1);
        check("dir.sub_b", 32'({b_err0, b_out0}), 32'd15);
        repeat (2) cycle(1'b0, 8'd0, 9'd0, 9'd0, 1'b1);

        // Backpressure: five back-to-back entries into a stalled consumer.
        reset_dut();
        repeat (5) cycle(1'b1, 8'($urandom), 9'($urandom), 9'($urandom), 1'b0);
        repeat (LAT) cycle(1'b0, 8'd0, 9'($urandom), 9'($urandom), 1'b0);
        check("bp.ovf", 32'(ovf1), 32'd1);
        repeat (6) cycle(1'b0, 8'd0, 9'd0, 9'd0, 1'b1);
        check("bp.drained", 32'(out_valid1), 32'd0);

        // Full FIFO written and popped on the same edges.
        reset_dut();
        for (int k = 0; k < 14; k++) begin
            cycle((k < 8) ? 1'b1 : 1'b0, 8'($urandom), 9'($urandom), 9'($urandom),
                  (k >= 7) ? 1'b1 : 1'b0);
        end
        check("full.no_ovf_sum", 32'(ovf1), 32'd0);
        check("full.no_ovf_sub", 32'(ovf0), 32'd0);

        // Reset one edge after an issue: nothing may emerge afterwards.
        reset_dut();
        cycle(1'b1, 8'd77, 9'd0, 9'd0, 1'b1);
        reset_dut();
        repeat (LAT + 3) cycle(1'b0, 8'd0, 9'($urandom), 9'($urandom), 1'b1);
        check("rst.valid", 32'(out_valid1), 32'd0);
        check("rst.err_cnt", 32'(err_cnt1), 32'd0);

        // Random traffic, long enough to push err_cnt into saturation.
        reset_dut();
        repeat (1500) begin
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), 9'($urandom), 9'($urandom),
                  ($urandom_range(0, 4) < 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
